// File: rtl/csr_counter.sv
// Architectural cycle / retired-instruction counters feeding the execute-stage ALU.
// Optional software write path compiled in with `define CSR_CNT_WRITE_EN.
module csr_counter #(
    parameter int          CNT_W       = 64,
    parameter logic [63:0] RST_CYCLE   = 64'd0,
    parameter logic [63:0] RST_INSTRET = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    input  logic        inhibit_cy,
    input  logic        inhibit_ir,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic [63:0] cycle,
    output logic [63:0] instr_cnt,
    output logic        cy_wrap,
    output logic        ir_wrap
);

    logic [CNT_W-1:0] cy_q, cy_d;
    logic [CNT_W-1:0] ir_q, ir_d;
    logic             cy_wrap_q, cy_wrap_d;
    logic             ir_wrap_q, ir_wrap_d;

    logic             cy_wr, ir_wr;
    logic             wr_hi;
    logic [31:0]      wr_word;
    logic             cy_inc, ir_inc;

`ifdef CSR_CNT_WRITE_EN
    assign cy_wr   = wr_en & ~wr_sel[1];
    assign ir_wr   = wr_en &  wr_sel[1];
    assign wr_hi   = wr_sel[0];
    assign wr_word = wr_data;
`else
    assign cy_wr   = 1'b0;
    assign ir_wr   = 1'b0;
    assign wr_hi   = 1'b0;
    assign wr_word = '0;

    logic unused_wr;
    assign unused_wr = &{1'b0, wr_en, wr_sel, wr_data};
`endif

    // A write to a counter suppresses its increment; a retire coinciding with
    // an instret write is deliberately lost.
    assign cy_inc = ~cy_wr & ~inhibit_cy;
    assign ir_inc = ~ir_wr & retire & ~inhibit_ir;

    always_comb begin
        cy_d      = cy_q;
        cy_wrap_d = 1'b0;
        if (cy_wr) begin
            if (wr_hi) cy_d[63:32] = wr_word;
            else       cy_d[31:0]  = wr_word;
        end else if (cy_inc) begin
            cy_d      = cy_q + CNT_W'(1);
            cy_wrap_d = &cy_q;
        end
    end

    always_comb begin
        ir_d      = ir_q;
        ir_wrap_d = 1'b0;
        if (ir_wr) begin
            if (wr_hi) ir_d[63:32] = wr_word;
            else       ir_d[31:0]  = wr_word;
        end else if (ir_inc) begin
            ir_d      = ir_q + CNT_W'(1);
            ir_wrap_d = &ir_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cy_q      <= RST_CYCLE;
            ir_q      <= RST_INSTRET;
            cy_wrap_q <= 1'b0;
            ir_wrap_q <= 1'b0;
        end else begin
            cy_q      <= cy_d;
            ir_q      <= ir_d;
            cy_wrap_q <= cy_wrap_d;
            ir_wrap_q <= ir_wrap_d;
        end
    end

    assign cycle     = cy_q;
    assign instr_cnt = ir_q;
    assign cy_wrap   = cy_wrap_q;
    assign ir_wrap   = ir_wrap_q;

endmodule

// File: tb/tb_csr_counter.sv
// Self-checking bench for csr_counter: behavioural model of two instances
// (default reset values and near-wrap reset values), directed and random stimulus.
module tb_csr_counter;

    localparam logic [63:0] RC1 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] RI1 = 64'hFFFF_FFFF_FFFF_FFFD;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire, inhibit_cy, inhibit_ir, wr_en;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;

    logic [63:0] cycle0, instr0, cycle1, instr1;
    logic        cyw0, irw0, cyw1, irw1;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    logic [63:0] m_cy [2];
    logic [63:0] m_ir [2];
    logic        m_cw [2];
    logic        m_iw [2];
    logic [63:0] rst_cy [2];
    logic [63:0] rst_ir [2];

    csr_counter #(.CNT_W(64), .RST_CYCLE(64'd0), .RST_INSTRET(64'd0)) dut0 (
        .clk(clk), .rst(rst), .retire(retire), .inhibit_cy(inhibit_cy),
        .inhibit_ir(inhibit_ir), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .cycle(cycle0), .instr_cnt(instr0), .cy_wrap(cyw0), .ir_wrap(irw0)
    );

    csr_counter #(.CNT_W(64), .RST_CYCLE(RC1), .RST_INSTRET(RI1)) dut1 (
        .clk(clk), .rst(rst), .retire(retire), .inhibit_cy(inhibit_cy),
        .inhibit_ir(inhibit_ir), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .cycle(cycle1), .instr_cnt(instr1), .cy_wrap(cyw1), .ir_wrap(irw1)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level rule for one counter over one clock edge.
    function automatic void step(input logic [63:0] cur, input bit inc, input bit wr,
                                 input bit hi, input logic [31:0] d,
                                 output logic [63:0] nxt, output logic wrap);
        if (wr) begin
            nxt  = hi ? {d, cur[31:0]} : {cur[63:32], d};
            wrap = 1'b0;
        end else if (inc) begin
            nxt  = cur + 64'd1;
            wrap = (nxt == 64'd0);
        end else begin
            nxt  = cur;
            wrap = 1'b0;
        end
    endfunction

    logic [63:0] nc, ni;
    logic        wc, wi;
    bit          cwr, iwr;

    initial begin
        rst_cy[0] = 64'd0; rst_ir[0] = 64'd0;
        rst_cy[1] = RC1;   rst_ir[1] = RI1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cy[i] = rst_cy[i]; m_ir[i] = rst_ir[i];
                m_cw[i] = 1'b0;      m_iw[i] = 1'b0;
            end
        end else begin
`ifdef CSR_CNT_WRITE_EN
            cwr = wr_en && (wr_sel == 2'd0 || wr_sel == 2'd1);
            iwr = wr_en && (wr_sel == 2'd2 || wr_sel == 2'd3);
`else
            cwr = 1'b0;
            iwr = 1'b0;
`endif
            for (int i = 0; i < 2; i++) begin
                step(m_cy[i], !inhibit_cy, cwr, wr_sel[0], wr_data, nc, wc);
                step(m_ir[i], retire && !inhibit_ir, iwr, wr_sel[0], wr_data, ni, wi);
                m_cy[i] = nc; m_cw[i] = wc;
                m_ir[i] = ni; m_iw[i] = wi;
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            check64("cycle0",   cycle0, m_cy[0]);
            check64("instr0",   instr0, m_ir[0]);
            check64("cy_wrap0", {63'd0, cyw0}, {63'd0, m_cw[0]});
            check64("ir_wrap0", {63'd0, irw0}, {63'd0, m_iw[0]});
            check64("cycle1",   cycle1, m_cy[1]);
            check64("instr1",   instr1, m_ir[1]);
            check64("cy_wrap1", {63'd0, cyw1}, {63'd0, m_cw[1]});
            check64("ir_wrap1", {63'd0, irw1}, {63'd0, m_iw[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  r_pat, i_pat;
    logic [63:0] base_cy, base_ir;

    initial begin
        rst = 1'b0; retire = 1'b0; inhibit_cy = 1'b0; inhibit_ir = 1'b0;
        wr_en = 1'b0; wr_sel = 2'd0; wr_data = 32'd0;
        #1 rst = 1'b1;
        #2;
        check64("rst_cycle0", cycle0, 64'd0);
        check64("rst_cycle1", cycle1, RC1);
        check64("rst_instr1", instr1, RI1);
        tick(); tick();
        rst = 1'b0;
        started = 1'b1;

        // Ten idle cycles after release.
        repeat (10) tick();
        check64("idle_cycle", cycle0, 64'd10);
        check64("idle_instr", instr0, 64'd0);
        check64("idle_cycle1_wrapped", cycle1, 64'd2);

        // Five retires over eight cycles, two of them inhibited.
        r_pat = 8'b1101_1010;
        i_pat = 8'b0100_1000;
        base_ir = m_ir[0];
        for (int i = 0; i < 8; i++) begin
            retire = r_pat[i]; inhibit_ir = i_pat[i];
            tick();
        end
        retire = 1'b0; inhibit_ir = 1'b0;
        tick();
        check64("retire_plus3", instr0, base_ir + 64'd3);

`ifdef CSR_CNT_WRITE_EN
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 32'hFFFF_FFFF; tick();
        wr_sel = 2'd0; wr_data = 32'hFFFF_FFFE; tick();
        wr_en = 1'b0;
        check64("wr_cycle", cycle0, 64'hFFFF_FFFF_FFFF_FFFE);
        check64("wr_nowrap", {63'd0, cyw0}, 64'd0);
        tick(); tick();
        check64("wrap_cycle", cycle0, 64'd0);
        check64("wrap_pulse", {63'd0, cyw0}, 64'd1);
        tick();
        check64("wrap_end", {63'd0, cyw0}, 64'd0);
        check64("wrap_next", cycle0, 64'd1);

        wr_en = 1'b1; wr_sel = 2'd3; wr_data = 32'h5; tick();
        wr_sel = 2'd2; wr_data = 32'h7; tick();
        check64("ir_preset", instr0, 64'h0000_0005_0000_0007);
        wr_data = 32'h100; retire = 1'b1; tick();
        wr_en = 1'b0; retire = 1'b0;
        check64("wr_beats_retire", instr0, 64'h0000_0005_0000_0100);
        tick();
`else
        base_cy = m_cy[0];
        base_ir = m_ir[0];
        wr_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_sel = 2'($urandom_range(0, 3));
            wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        check64("ro_cycle", cycle0, base_cy + 64'd20);
        check64("ro_instr", instr0, base_ir);
`endif

        // Asynchronous reset mid-cycle with a retire and write pending.
        retire = 1'b1; wr_en = 1'b1; wr_sel = 2'd2; wr_data = 32'hABCD;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check64("async_cycle0", cycle0, 64'd0);
        check64("async_instr0", instr0, 64'd0);
        check64("async_cyw",    {63'd0, cyw0}, 64'd0);
        check64("async_cycle1", cycle1, RC1);
        retire = 1'b0; wr_en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check64("restart_cycle", cycle0, 64'd3);
        check64("restart_instr", instr0, 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            retire     = 1'($urandom_range(0, 1));
            inhibit_cy = ($urandom_range(0, 7) == 0);
            inhibit_ir = ($urandom_range(0, 7) == 0);
            wr_en      = ($urandom_range(0, 15) == 0);
            wr_sel     = 2'($urandom_range(0, 3));
            wr_data    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            tick();
        end
        retire = 1'b0; inhibit_cy = 1'b0; inhibit_ir = 1'b0; wr_en = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
